// File: rtl/ram_arbiter.sv
// Round-robin arbiter letting two masters share one block RAM port.
// Out-of-window addresses are acknowledged with err and never reach the RAM.
module ram_arbiter #(
  parameter int          ABITS = 32,
  parameter int          DBITS = 32,
  parameter int unsigned BASE  = 32'd0,
  parameter int unsigned SIZE  = 32'd1024
) (
  input  logic             clka,
  input  logic             reset_n,
  input  logic             r0_req,
  input  logic             r0_we,
  input  logic [ABITS-1:0] r0_addr,
  input  logic [DBITS-1:0] r0_wdata,
  input  logic             r1_req,
  input  logic             r1_we,
  input  logic [ABITS-1:0] r1_addr,
  input  logic [DBITS-1:0] r1_wdata,
  output logic             r0_ack,
  output logic             r0_err,
  output logic             r0_rvalid,
  output logic [DBITS-1:0] r0_rdata,
  output logic             r1_ack,
  output logic             r1_err,
  output logic             r1_rvalid,
  output logic [DBITS-1:0] r1_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [ABITS-1:0] mem_addr,
  output logic [DBITS-1:0] mem_wdata,
  input  logic [DBITS-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RDATA = 2'd2
  } state_t;

  // Window limit is one bit wider so BASE+SIZE cannot wrap.
  localparam logic [ABITS:0] BASE_W  = (ABITS+1)'(BASE);
  localparam logic [ABITS:0] LIMIT_W = BASE_W + (ABITS+1)'(SIZE);

  function automatic logic in_window(input logic [ABITS-1:0] addr);
    in_window = ({1'b0, addr} >= BASE_W) && ({1'b0, addr} < LIMIT_W);
  endfunction

  state_t             state_r, state_s;
  logic               last_r, last_s;
  logic               win_r, win_s;
  logic [1:0]         ack_r, ack_s;
  logic [1:0]         err_r, err_s;
  logic [1:0]         rvalid_r, rvalid_s;
  logic [DBITS-1:0]   rdata0_r, rdata0_s;
  logic [DBITS-1:0]   rdata1_r, rdata1_s;
  logic               mem_en_r, mem_en_s;
  logic               mem_we_r, mem_we_s;
  logic [ABITS-1:0]   mem_addr_r, mem_addr_s;
  logic [DBITS-1:0]   mem_wdata_r, mem_wdata_s;

  logic               pick_s;
  logic               sel_we_s;
  logic [ABITS-1:0]   sel_addr_s;
  logic [DBITS-1:0]   sel_wdata_s;

  // Winner selection: on a tie the port that was not granted last wins.
  always_comb begin
    pick_s = 1'b0;
    if (r0_req && r1_req) begin
      pick_s = ~last_r;
    end else begin
      pick_s = r1_req;
    end
    sel_we_s    = pick_s ? r1_we    : r0_we;
    sel_addr_s  = pick_s ? r1_addr  : r0_addr;
    sel_wdata_s = pick_s ? r1_wdata : r0_wdata;
  end

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_s     = state_r;
    last_s      = last_r;
    win_s       = win_r;
    ack_s       = 2'b00;
    err_s       = 2'b00;
    rvalid_s    = 2'b00;
    rdata0_s    = rdata0_r;
    rdata1_s    = rdata1_r;
    mem_en_s    = mem_en_r;
    mem_we_s    = mem_we_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    case (state_r)
      IDLE: begin
        if (r0_req || r1_req) begin
          win_s          = pick_s;
          last_s         = pick_s;
          ack_s[pick_s]  = 1'b1;
          err_s[pick_s]  = ~in_window(sel_addr_s);
          mem_en_s       = in_window(sel_addr_s);
          mem_we_s       = sel_we_s;
          mem_addr_s     = sel_addr_s;
          mem_wdata_s    = sel_wdata_s;
          state_s        = CMD;
        end else begin
          mem_en_s = 1'b0;
          mem_we_s = 1'b0;
        end
      end
      CMD: begin
        mem_we_s = 1'b0;
        // mem_en low here means the address was rejected.
        if (mem_en_r && !mem_we_r) begin
          mem_en_s = 1'b1;
          state_s  = RDATA;
        end else begin
          mem_en_s = 1'b0;
          state_s  = IDLE;
        end
      end
      RDATA: begin
        mem_en_s        = 1'b0;
        rvalid_s[win_r] = 1'b1;
        if (win_r) begin
          rdata1_s = mem_rdata;
        end else begin
          rdata0_s = mem_rdata;
        end
        state_s = IDLE;
      end
      default: begin
        mem_en_s = 1'b0;
        mem_we_s = 1'b0;
        state_s  = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clka) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      last_r      <= 1'b1;
      win_r       <= 1'b0;
      ack_r       <= 2'b00;
      err_r       <= 2'b00;
      rvalid_r    <= 2'b00;
      rdata0_r    <= '0;
      rdata1_r    <= '0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else begin
      state_r     <= state_s;
      last_r      <= last_s;
      win_r       <= win_s;
      ack_r       <= ack_s;
      err_r       <= err_s;
      rvalid_r    <= rvalid_s;
      rdata0_r    <= rdata0_s;
      rdata1_r    <= rdata1_s;
      mem_en_r    <= mem_en_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
    end
  end

  assign r0_ack    = ack_r[0];
  assign r1_ack    = ack_r[1];
  assign r0_err    = err_r[0];
  assign r1_err    = err_r[1];
  assign r0_rvalid = rvalid_r[0];
  assign r1_rvalid = rvalid_r[1];
  assign r0_rdata  = rdata0_r;
  assign r1_rdata  = rdata1_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM attached.
module tb_ram_arbiter;

  logic        clka = 1'b0;
  logic        reset_n;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_ack, r0_err, r0_rvalid, r1_ack, r1_err, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] ram [0:1023];
  logic [31:0] ram_q;
  int          errors = 0;
  int          checks = 0;

  always #5 clka = ~clka;

  ram_arbiter #(.ABITS(32), .DBITS(32), .BASE(0), .SIZE(1024)) dut (
    .clka(clka), .reset_n(reset_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_ack(r0_ack), .r0_err(r0_err), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_ack(r1_ack), .r1_err(r1_err), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // RAM with registered read; output is garbage whenever it is not being read.
  always @(posedge clka) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
      else ram_q <= ram[mem_addr[9:0]];
    end
  end
  assign mem_rdata = (mem_en && !mem_we) ? ram_q : 32'hBAD0BAD0;

  wire [135:0] all_outs = {r0_ack, r1_ack, r0_err, r1_err, r0_rvalid, r1_rvalid,
                           mem_en, mem_we, mem_addr, mem_wdata, r0_rdata, r1_rdata};

  task automatic tick();
    @(negedge clka);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (all_outs !== 136'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs);
    end
  endtask

  task automatic test_write_read();
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'd5; r0_wdata = 32'hDEADBEEF;
    tick();
    checks++;
    if ({r0_ack, r0_err, mem_en, mem_we} !== 4'b1011 || mem_addr !== 32'd5 || mem_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_cmd: ack/err/en/we=%b addr=%h wdata=%h expected 1011 5 deadbeef",
                         {r0_ack, r0_err, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    r0_req = 1'b0;
    tick();
    checks++;
    if (r0_ack !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL wr_done: ack=%b en=%b expected 0 0", r0_ack, mem_en);
    end
    r0_req = 1'b1; r0_we = 1'b0;
    tick();
    checks++;
    if ({r0_ack, mem_en, mem_we} !== 3'b110) begin
      errors++; $display("FAIL rd_cmd: ack/en/we=%b expected 110", {r0_ack, mem_en, mem_we});
    end
    r0_req = 1'b0;
    tick();
    checks++;
    if (mem_en !== 1'b1 || r0_rvalid !== 1'b0) begin
      errors++; $display("FAIL rd_rdata_phase: en=%b rvalid=%b expected 1 0", mem_en, r0_rvalid);
    end
    tick();
    checks++;
    if (r0_rvalid !== 1'b1 || r0_rdata !== 32'hDEADBEEF || r1_rvalid !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL rd_data: rvalid=%b rdata=%h r1_rvalid=%b en=%b expected 1 deadbeef 0 0",
                         r0_rvalid, r0_rdata, r1_rvalid, mem_en);
    end
    tick();
    checks++;
    if (r0_rvalid !== 1'b0 || r0_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_hold: rvalid=%b rdata=%h expected 0 deadbeef", r0_rvalid, r0_rdata);
    end
  endtask

  task automatic test_tie_after_reset();
    test_reset();
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'd5;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'd7;
    tick();
    checks++;
    if ({r0_ack, r1_ack} !== 2'b10) begin
      errors++; $display("FAIL tie_first: r0/r1 ack=%b expected 10", {r0_ack, r1_ack});
    end
    r0_req = 1'b0;
    tick();
    tick();
    checks++;
    if (r0_rvalid !== 1'b1 || r0_rdata !== 32'hDEADBEEF || r1_ack !== 1'b0) begin
      errors++; $display("FAIL tie_r0_data: rvalid=%b rdata=%h r1_ack=%b expected 1 deadbeef 0",
                         r0_rvalid, r0_rdata, r1_ack);
    end
    tick();
    checks++;
    if ({r0_ack, r1_ack} !== 2'b01) begin
      errors++; $display("FAIL tie_second: r0/r1 ack=%b expected 01", {r0_ack, r1_ack});
    end
    r1_req = 1'b0;
    tick(); tick();
    checks++;
    if (r1_rvalid !== 1'b1 || r1_rdata !== 32'hA5000007 || r0_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL tie_r1_data: rvalid=%b rdata=%h r0_rdata=%h expected 1 a5000007 deadbeef",
                         r1_rvalid, r1_rdata, r0_rdata);
    end
  endtask

  task automatic test_alternate();
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'd10; r0_wdata = 32'h11110000;
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'd20; r1_wdata = 32'h22220000;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (r0_ack !== (k % 4 == 1) || r1_ack !== (k % 4 == 3)) begin
        errors++; $display("FAIL alternate cycle %0d: r0_ack=%b r1_ack=%b expected %b %b",
                           k, r0_ack, r1_ack, (k % 4 == 1), (k % 4 == 3));
      end
      if (k % 4 == 3) begin
        checks++;
        if (mem_addr !== 32'd20 || mem_wdata !== 32'h22220000) begin
          errors++; $display("FAIL alternate_r1_cmd: addr=%h wdata=%h expected 14 22220000", mem_addr, mem_wdata);
        end
      end
    end
    r0_req = 1'b0; r1_req = 1'b0;
    tick();
  endtask

  task automatic test_out_of_window();
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'd1024;
    tick();
    checks++;
    if ({r1_ack, r1_err, mem_en, r0_ack} !== 4'b1100) begin
      errors++; $display("FAIL oow_ack: ack/err/en/r0_ack=%b expected 1100", {r1_ack, r1_err, mem_en, r0_ack});
    end
    r1_req = 1'b0;
    tick();
    checks++;
    if ({r1_ack, r1_err, mem_en} !== 3'b000) begin
      errors++; $display("FAIL oow_after: ack/err/en=%b expected 000", {r1_ack, r1_err, mem_en});
    end
    r1_req = 1'b1; r1_addr = 32'd1023;
    tick();
    checks++;
    if ({r1_ack, r1_err, mem_en, r1_rvalid} !== 4'b1010) begin
      errors++; $display("FAIL edge_ack: ack/err/en/rvalid=%b expected 1010", {r1_ack, r1_err, mem_en, r1_rvalid});
    end
    r1_req = 1'b0;
    tick();
    tick();
    checks++;
    if (r1_rvalid !== 1'b1 || r1_rdata !== 32'hA50003FF) begin
      errors++; $display("FAIL edge_data: rvalid=%b rdata=%h expected 1 a50003ff", r1_rvalid, r1_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'd5;
    tick();
    r0_req = 1'b0;
    tick();
    checks++;
    if (mem_en !== 1'b1) begin
      errors++; $display("FAIL mid_rdata_phase: en=%b expected 1", mem_en);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if (all_outs !== 136'd0) begin
      errors++; $display("FAIL mid_reset_outputs: got %h expected 0", all_outs);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (r0_rvalid !== 1'b0 || r0_ack !== 1'b0) begin
        errors++; $display("FAIL mid_no_rvalid cycle %0d: rvalid=%b ack=%b expected 0 0", k, r0_rvalid, r0_ack);
      end
    end
    r0_req = 1'b1; r0_addr = 32'd7;
    tick();
    r0_req = 1'b0;
    checks++;
    if (r0_ack !== 1'b1) begin
      errors++; $display("FAIL mid_resume_ack: ack=%b expected 1", r0_ack);
    end
    tick(); tick();
    checks++;
    if (r0_rvalid !== 1'b1 || r0_rdata !== 32'hA5000007) begin
      errors++; $display("FAIL mid_resume_data: rvalid=%b rdata=%h expected 1 a5000007", r0_rvalid, r0_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'd0; r0_wdata = 32'hC0DE0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (r0_ack !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== i || mem_wdata !== (32'hC0DE0000 + i)) begin
        errors++; $display("FAIL b2b_write %0d: ack=%b en=%b we=%b addr=%h wdata=%h", i, r0_ack, mem_en, mem_we, mem_addr, mem_wdata);
      end
      if (i < 3) begin
        r0_addr = i + 1; r0_wdata = 32'hC0DE0000 + i + 1;
      end else begin
        r0_req = 1'b0;
      end
      tick();
      checks++;
      if (r0_ack !== 1'b0) begin
        errors++; $display("FAIL b2b_gap %0d: ack=%b expected 0", i, r0_ack);
      end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (mem_en !== 1'b0) begin
        errors++; $display("FAIL idle_en cycle %0d: en=%b expected 0", k, mem_en);
      end
    end
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (r0_ack !== 1'b1 || mem_addr !== i || mem_we !== 1'b0) begin
        errors++; $display("FAIL b2b_read_cmd %0d: ack=%b addr=%h we=%b", i, r0_ack, mem_addr, mem_we);
      end
      if (i < 3) r0_addr = i + 1;
      else r0_req = 1'b0;
      tick();
      tick();
      checks++;
      if (r0_rvalid !== 1'b1 || r0_rdata !== (32'hC0DE0000 + i)) begin
        errors++; $display("FAIL b2b_read_data %0d: rvalid=%b rdata=%h expected 1 %h", i, r0_rvalid, r0_rdata, 32'hC0DE0000 + i);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'hA5000000 | i;
    ram_q = 32'd0;
    reset_n = 1'b0;
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = 32'd0; r0_wdata = 32'd0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = 32'd0; r1_wdata = 32'd0;
    test_reset();
    test_write_read();
    test_tie_after_reset();
    test_alternate();
    test_out_of_window();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
